// File: rtl/deshifter8.sv
// Serial-in/parallel-out receiver with a one-entry valid/ready output buffer.
// Define DESHIFT8_PARITY_EN to add an even-parity bit per frame and the parity_err output.
module deshifter8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             s_valid,
  input  logic             s_in,
  input  logic             d_ready,
  output logic             d_valid,
  output logic [WIDTH-1:0] d_out,
  output logic [CW-1:0]    bit_cnt,
  output logic             overflow
`ifdef DESHIFT8_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word;
  logic             in_data;
  logic             last_data;
  logic             complete;
  logic             accept;

`ifdef DESHIFT8_PARITY_EN
  typedef enum logic {DATA, PAR} state_t;
  state_t state;
  logic   perr_calc;

  assign in_data   = (state == DATA);
  // The data word is already complete in sr while the parity bit arrives.
  assign complete  = s_valid && (state == PAR);
  assign word      = sr;
  assign perr_calc = (^sr) ^ s_in;
`else
  assign in_data   = 1'b1;
  assign complete  = last_data;
  assign word      = sr_shift;
`endif

  always_comb begin
    sr_shift = sr;
    if (MSB_FIRST)
      sr_shift = {sr[WIDTH-2:0], s_in};
    else
      sr_shift = {s_in, sr[WIDTH-1:1]};
  end

  assign last_data = s_valid && in_data && (bit_cnt == CW'(WIDTH - 1));
  // A completed word fits if the buffer is empty or is drained this same cycle.
  assign accept    = complete && (!d_valid || d_ready);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr       <= '0;
      bit_cnt  <= '0;
      d_out    <= '0;
      d_valid  <= 1'b0;
      overflow <= 1'b0;
`ifdef DESHIFT8_PARITY_EN
      state      <= DATA;
      parity_err <= 1'b0;
`endif
    end else begin
      if (s_valid) begin
`ifdef DESHIFT8_PARITY_EN
        if (state == DATA) begin
          sr <= sr_shift;
          if (last_data) begin
            state   <= PAR;
            bit_cnt <= CW'(WIDTH);
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end else begin
          state   <= DATA;
          bit_cnt <= '0;
        end
`else
        sr      <= sr_shift;
        bit_cnt <= last_data ? '0 : bit_cnt + CW'(1);
`endif
      end

      if (complete) begin
        if (accept) begin
          d_out   <= word;
          d_valid <= 1'b1;
`ifdef DESHIFT8_PARITY_EN
          parity_err <= perr_calc;
`endif
        end else begin
          overflow <= 1'b1;
        end
      end else if (d_valid && d_ready) begin
        d_valid <= 1'b0;
`ifdef DESHIFT8_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
    end
  end

endmodule
